// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: I-fetch, D-access and memory-port signals of mem_arbiter.
// slave is the arbiter's view; master is the view of the surrounding requesters and memory.
interface mem_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_done;
   logic [31:0] i_rdata;
   logic        i_err;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_gnt;
   logic        d_done;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_ack;
   logic [31:0] m_rdata;
   logic        busy;
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_ack, m_rdata,
      output i_gnt, i_done, i_rdata, i_err, d_gnt, d_done, d_rdata, d_err,
      output m_req, m_we, m_addr, m_wdata, m_wstrb, busy
   );
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_ack, m_rdata,
      input  i_gnt, i_done, i_rdata, i_err, d_gnt, d_done, d_rdata, d_err,
      input  m_req, m_we, m_addr, m_wdata, m_wstrb, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I-fetch reads and D accesses onto one memory port, D first with I anti-starvation.
// Define ARB_TIMEOUT_EN to abort a MEM phase after TIMEOUT_CYCLES without m_ack and report err.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
`ifdef ARB_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input logic clk,
   input logic rst,
   mem_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, MEM = 2'd1, RESP = 2'd2;
   localparam int SW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
   logic [1:0] state;
   logic owner_d;
   logic [SW-1:0] streak;
   logic i_win, d_win, ack, tmo;
   always_comb begin
      i_win = bus.i_req && (!bus.d_req || (STARVE_LIMIT != 0 && streak == LIM));
      d_win = bus.d_req && !i_win;
      ack = state == MEM && bus.m_ack;
   end
`ifdef ARB_TIMEOUT_EN
   logic [15:0] tcnt;
   // ack in the final cycle takes precedence over the abort
   assign tmo = state == MEM && !bus.m_ack && tcnt == 16'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk)
      tcnt <= (rst || state != MEM) ? 16'd0 : tcnt + 16'd1;
   always_ff @(posedge clk) begin
      bus.i_err <= !rst && tmo && !owner_d;
      bus.d_err <= !rst && tmo && owner_d;
   end
`else
   assign tmo = 1'b0;
   assign bus.i_err = 1'b0;
   assign bus.d_err = 1'b0;
`endif
   assign bus.busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner_d <= 1'b0;
         streak <= '0;
         bus.i_gnt <= 1'b0;
         bus.d_gnt <= 1'b0;
         bus.i_done <= 1'b0;
         bus.d_done <= 1'b0;
         bus.i_rdata <= '0;
         bus.d_rdata <= '0;
         bus.m_req <= 1'b0;
         bus.m_we <= 1'b0;
         bus.m_addr <= '0;
         bus.m_wdata <= '0;
         bus.m_wstrb <= '0;
      end else begin
         bus.i_gnt <= state == IDLE && i_win;
         bus.d_gnt <= state == IDLE && d_win;
         bus.i_done <= (ack || tmo) && !owner_d;
         bus.d_done <= (ack || tmo) && owner_d;
         if (state == IDLE && (i_win || d_win)) begin
            state <= MEM;
            owner_d <= d_win;
            bus.m_req <= 1'b1;
            bus.m_we <= d_win && bus.d_we;
            bus.m_addr <= d_win ? bus.d_addr : bus.i_addr;
            bus.m_wdata <= d_win ? bus.d_wdata : '0;
            bus.m_wstrb <= (d_win && bus.d_we) ? bus.d_wstrb : 4'b0000;
            streak <= i_win ? '0 : (bus.i_req && streak != LIM) ? streak + 1'b1 : streak;
         end
         if (ack || tmo) begin
            state <= RESP;
            bus.m_req <= 1'b0;
         end
         if (ack && !bus.m_we && !owner_d) bus.i_rdata <= bus.m_rdata;
         if (ack && !bus.m_we && owner_d) bus.d_rdata <= bus.m_rdata;
         if (state == RESP) state <= IDLE;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, starvation/reset/timeout sequences and random traffic
// checked cycle by cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;
   localparam int LIM = 4;
   localparam int TMO = 8;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   mem_arbiter_if bus();
   mem_arbiter #(
      .STARVE_LIMIT(LIM)
`ifdef ARB_TIMEOUT_EN
      , .TIMEOUT_CYCLES(TMO)
`endif
   ) dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {
      bit sd;
      bit we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [3:0] strb;
      int dly;
      bit e_we;
      logic [3:0] e_strb;
      int e_lat;
      logic [31:0] e_ir;
      logic [31:0] e_dr;
   } vec_t;
   int checks = 0, failures = 0, cyc_n = 0;
   bit rst_v, i_req_v, i_hold, d_req_v, d_hold, d_we_v, rand_mode;
   logic [31:0] i_addr_v, d_addr_v, d_wdata_v, rd_v;
   logic [3:0] d_wstrb_v;
   int ack_delay;
   int ph, streak, cnt;
   bit own_d, e_ig, e_dg, e_id, e_dd, e_ie, e_de, e_mreq, e_mwe;
   logic [31:0] e_maddr, e_mwdata, e_ir, e_dr;
   logic [3:0] e_mstrb;
   string grants;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask
   // One clock: check this cycle's outputs, drive this cycle's inputs, predict next cycle.
   task automatic cyc();
      bit ack, iw, to;
      @(negedge clk);
      cyc_n++;
      chk("i_gnt", bus.i_gnt, e_ig);
      chk("d_gnt", bus.d_gnt, e_dg);
      chk("i_done", bus.i_done, e_id);
      chk("d_done", bus.d_done, e_dd);
      chk("i_err", bus.i_err, e_ie);
      chk("d_err", bus.d_err, e_de);
      chk("m_req", bus.m_req, e_mreq);
      chk("busy", bus.busy, ph != 0);
      chk("i_rdata", bus.i_rdata, e_ir);
      chk("d_rdata", bus.d_rdata, e_dr);
      if (e_mreq) begin
         chk("m_addr", bus.m_addr, e_maddr);
         chk("m_we", bus.m_we, e_mwe);
         chk("m_wstrb", bus.m_wstrb, e_mstrb);
         if (e_mwe) chk("m_wdata", bus.m_wdata, e_mwdata);
      end
      if (bus.i_gnt) grants = {grants, "I"};
      if (bus.d_gnt) grants = {grants, "D"};
      if (e_id && !i_hold) i_req_v = 1'b0;
      if (e_dd && !d_hold) d_req_v = 1'b0;
      ack = 1'b0;
      if (ph == 1) ack = ack_delay >= 0 && cnt == ack_delay;
      else if (rand_mode) ack = $urandom_range(0, 1) == 1;
      rst = rst_v;
      bus.i_req = i_req_v;
      bus.i_addr = i_addr_v;
      bus.d_req = d_req_v;
      bus.d_we = d_we_v;
      bus.d_addr = d_addr_v;
      bus.d_wdata = d_wdata_v;
      bus.d_wstrb = d_wstrb_v;
      bus.m_ack = ack;
      bus.m_rdata = ack ? rd_v : $urandom();
      {e_ig, e_dg, e_id, e_dd, e_ie, e_de} = '0;
      to = 1'b0;
      if (rst_v) begin
         ph = 0; streak = 0; cnt = 0; own_d = 0;
         e_mreq = 0; e_mwe = 0; e_maddr = 0; e_mwdata = 0; e_mstrb = 0; e_ir = 0; e_dr = 0;
      end else if (ph == 0) begin
         if (i_req_v || d_req_v) begin
            iw = i_req_v && (!d_req_v || (LIM != 0 && streak == LIM));
            own_d = !iw;
            e_ig = iw;
            e_dg = !iw;
            streak = iw ? 0 : (i_req_v ? ((streak + 1 > LIM) ? LIM : streak + 1) : streak);
            e_mreq = 1;
            e_mwe = !iw && d_we_v;
            e_maddr = iw ? i_addr_v : d_addr_v;
            e_mwdata = d_wdata_v;
            e_mstrb = e_mwe ? d_wstrb_v : 4'h0;
            ph = 1;
            cnt = 0;
            if (rand_mode) ack_delay = $urandom_range(0, 4);
         end
      end else if (ph == 1) begin
`ifdef ARB_TIMEOUT_EN
         to = !ack && cnt + 1 == TMO;
`endif
         if (ack || to) begin
            ph = 2;
            e_mreq = 0;
            if (own_d) begin e_dd = 1; e_de = to; end
            else begin e_id = 1; e_ie = to; end
            if (ack && !e_mwe) begin
               if (own_d) e_dr = rd_v;
               else e_ir = rd_v;
            end
         end else cnt++;
      end else ph = 0;
   endtask
   task automatic txn(input vec_t v, output int lat, output bit we_s, output logic [3:0] strb_s, output bit err_s);
      int start;
      lat = -1; we_s = 0; strb_s = 0; err_s = 0;
      if (v.sd) begin
         d_req_v = 1; d_we_v = v.we; d_addr_v = v.addr; d_wdata_v = v.wdata; d_wstrb_v = v.strb;
      end else begin
         i_req_v = 1; i_addr_v = v.addr;
      end
      rd_v = v.rdata;
      ack_delay = v.dly;
      start = cyc_n + 1;
      for (int k = 0; k < 30 && lat < 0; k++) begin
         cyc();
         if (bus.i_gnt || bus.d_gnt) begin we_s = bus.m_we; strb_s = bus.m_wstrb; end
         if (bus.i_done || bus.d_done) begin lat = cyc_n - start; err_s = bus.i_err || bus.d_err; end
      end
      cyc();
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      vec_t vt[5];
      vec_t tv;
      int lat, dcnt;
      bit we_s, err_s;
      logic [3:0] strb_s;
      vt[0] = '{0, 0, 32'h00400000, 32'h0, 32'h00500093, 4'h0, 2, 0, 4'h0, 4, 32'h00500093, 32'h0};
      vt[1] = '{1, 1, 32'h10010000, 32'hDEADBEEF, 32'h13579BDF, 4'hF, 1, 1, 4'hF, 3, 32'h00500093, 32'h0};
      vt[2] = '{1, 0, 32'h10010004, 32'h0, 32'h12345678, 4'hF, 0, 0, 4'h0, 2, 32'h00500093, 32'h12345678};
      vt[3] = '{1, 1, 32'h10010008, 32'hCAFEF00D, 32'hFFFFFFFF, 4'h3, 3, 1, 4'h3, 5, 32'h00500093, 32'h12345678};
      vt[4] = '{0, 0, 32'h00400004, 32'h0, 32'h00A00113, 4'h0, 0, 0, 4'h0, 2, 32'h00A00113, 32'h12345678};
      rst = 1; rst_v = 1;
      {i_req_v, i_hold, d_req_v, d_hold, d_we_v, rand_mode} = '0;
      {i_addr_v, d_addr_v, d_wdata_v, rd_v} = '0;
      d_wstrb_v = 0; ack_delay = 0; grants = "";
      {bus.i_req, bus.d_req, bus.d_we, bus.m_ack} = '0;
      {bus.i_addr, bus.d_addr, bus.d_wdata, bus.m_rdata} = '0;
      bus.d_wstrb = 0;
      ph = 0; streak = 0; cnt = 0; own_d = 0;
      {e_ig, e_dg, e_id, e_dd, e_ie, e_de, e_mreq, e_mwe} = '0;
      {e_maddr, e_mwdata, e_ir, e_dr} = '0;
      e_mstrb = 0;
      repeat (3) cyc();
      rst_v = 0;
      repeat (2) cyc();
      chk("reset m_addr", bus.m_addr, 32'h0);
      chk("reset m_wdata", bus.m_wdata, 32'h0);
      foreach (vt[n]) begin
         txn(vt[n], lat, we_s, strb_s, err_s);
         chk($sformatf("vec%0d latency", n), lat, vt[n].e_lat);
         chk($sformatf("vec%0d m_we", n), we_s, vt[n].e_we);
         chk($sformatf("vec%0d m_wstrb", n), strb_s, vt[n].e_strb);
         chk($sformatf("vec%0d err", n), err_s, 1'b0);
         chk($sformatf("vec%0d i_rdata", n), bus.i_rdata, vt[n].e_ir);
         chk($sformatf("vec%0d d_rdata", n), bus.d_rdata, vt[n].e_dr);
      end
      i_hold = 1; d_hold = 1; i_req_v = 1; d_req_v = 1; d_we_v = 0;
      i_addr_v = 32'h00400008; d_addr_v = 32'h10010010; ack_delay = 0; grants = "";
      for (int k = 0; k < 80 && grants.len() < 10; k++) cyc();
      checks++;
      if (grants != "DDDDIDDDDI") begin
         failures++;
         $display("FAIL grant order: got %s expected DDDDIDDDDI", grants);
      end
      i_hold = 0; d_hold = 0; i_req_v = 0; d_req_v = 0;
      repeat (6) cyc();
      d_req_v = 1; d_we_v = 0; d_addr_v = 32'h10010020; ack_delay = -1;
      repeat (4) cyc();
      rst_v = 1; d_req_v = 0;
      cyc();
      rst_v = 0; ack_delay = 1;
      dcnt = 0;
      for (int k = 0; k < 12; k++) begin
         cyc();
         if (k == 0) begin
            chk("rst m_req", bus.m_req, 1'b0);
            chk("rst busy", bus.busy, 1'b0);
         end
         if (bus.d_done || bus.d_err) dcnt++;
      end
      chk("done after rst", dcnt, 0);
`ifdef ARB_TIMEOUT_EN
      tv = '{1, 0, 32'h10010030, 32'h0, 32'h0BADF00D, 4'hF, -1, 0, 4'h0, TMO + 1, 32'h0, 32'h0};
      txn(tv, lat, we_s, strb_s, err_s);
      chk("timeout latency", lat, TMO + 1);
      chk("timeout err", err_s, 1'b1);
      chk("timeout d_rdata kept", bus.d_rdata, 32'h0);
      tv.dly = TMO - 1;
      txn(tv, lat, we_s, strb_s, err_s);
      chk("ack at limit latency", lat, TMO + 1);
      chk("ack at limit err", err_s, 1'b0);
      chk("ack at limit d_rdata", bus.d_rdata, 32'h0BADF00D);
`endif
      rand_mode = 1;
      for (int k = 0; k < 800; k++) begin
         rst_v = $urandom_range(0, 199) == 0;
         if (!i_req_v && $urandom_range(0, 2) == 0) begin
            i_req_v = 1; i_addr_v = $urandom(); i_hold = $urandom_range(0, 3) == 0;
         end else if (i_hold && $urandom_range(0, 3) == 0) i_hold = 0;
         if (!d_req_v && $urandom_range(0, 2) == 0) begin
            d_req_v = 1; d_we_v = $urandom_range(0, 1) == 1; d_addr_v = $urandom();
            d_wdata_v = $urandom(); d_wstrb_v = 4'($urandom()); d_hold = $urandom_range(0, 3) == 0;
         end else if (d_hold && $urandom_range(0, 3) == 0) d_hold = 0;
         rd_v = $urandom();
         cyc();
      end
      rst_v = 0; i_hold = 0; d_hold = 0; i_req_v = 0; d_req_v = 0;
      repeat (12) cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
